// File: rtl/serial_add_ctrl.sv
//------------------------------------------------------------------------------
// Module   : serial_add_ctrl
// Brief    : Bit-serial WIDTH-bit adder built on one shared 1-bit adder slice.
//            Optional macro SERIAL_ADD_SUB_EN adds a 'sub' port (a - b).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_add_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state_q;
   logic [WIDTH-1:0] ra_q;
   logic [WIDTH-1:0] rb_q;
   logic [WIDTH-1:0] sum_q;
   logic [CNT_W-1:0] cnt_q;
   logic             carry_q;
   logic             cout_q;
   logic             busy_q;
   logic             done_q;

   // Shared slice: two half adders, carry is the OR of their generates.
   logic w_ha1_s;
   logic w_ha1_c;
   logic w_ha2_s;
   logic w_ha2_c;
   logic w_carry;

   assign w_ha1_s = ra_q[0] ^ rb_q[0];
   assign w_ha1_c = ra_q[0] & rb_q[0];
   assign w_ha2_s = w_ha1_s ^ carry_q;
   assign w_ha2_c = w_ha1_s & carry_q;
   assign w_carry = w_ha1_c | w_ha2_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ra_q    <= '0;
         rb_q    <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  ra_q    <= a;
`ifdef SERIAL_ADD_SUB_EN
                  rb_q    <= sub ? ~b : b;
                  carry_q <= sub;
`else
                  rb_q    <= b;
                  carry_q <= 1'b0;
`endif
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               sum_q   <= {w_ha2_s, sum_q[WIDTH-1:1]};
               ra_q    <= ra_q >> 1;
               rb_q    <= rb_q >> 1;
               carry_q <= w_carry;
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == C_LAST_BIT) begin
                  cout_q  <= w_carry;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

`default_nettype wire
